// File: rtl/conv_pkg.sv
// Shared sizing and FSM encoding for the conv1d window engine and its output stage.
package conv_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned N_IN    = 19;
    localparam int unsigned K       = 3;
    localparam int unsigned FRAC    = 8;
    localparam int unsigned ACC_W   = 2 * DATA_W + $clog2(K);
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned N_OUT   = N_IN - K + 1;
    localparam int unsigned TAP_W   = $clog2(K);
    localparam int unsigned WADDR_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_EMIT,
        ST_DONE
    } conv_state_e;

endpackage

// File: rtl/shift_sat.sv
// Arithmetic shift of a Q-format accumulator by FRAC, then saturation to DATA_W bits.
module shift_sat
    import conv_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic        [DATA_W-1:0] sat_o
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc_i >>> FRAC;
        if (shifted > MAX_V) begin
            sat_o = MAX_V[DATA_W-1:0];
        end else if (shifted < MIN_V) begin
            sat_o = MIN_V[DATA_W-1:0];
        end else begin
            sat_o = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/conv1d_window_engine.sv
// Slides a K-tap kernel over the input RAM, one MAC per fetched sample, and
// streams saturated window results over a valid/ready handshake.
module conv1d_window_engine
    import conv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               w_we,
    input  logic [WADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0]  w_data,
    output logic [ADDR_W-1:0]  ram_addr_read,
    output logic               ram_read_enable,
    input  logic [DATA_W-1:0]  ram_data_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [ADDR_W-1:0]  out_index,
    output logic               busy,
    output logic               done
);

    conv_state_e             state_q, state_d;
    logic [ADDR_W-1:0]       i_q, i_d;
    logic [TAP_W-1:0]        j_q, j_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [DATA_W-1:0] w_q [K];

    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    rd_en_q, rd_en_d;
    logic                    valid_q, valid_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [ADDR_W-1:0]       index_q, index_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [TAP_W-1:0]          tap;
    logic signed [DATA_W-1:0]  w_sel;
    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]         sat_res;
    logic                      w_wr;

    // Data returned now belongs to the read issued last cycle, i.e. tap j-1.
    assign tap   = (state_q == ST_FETCH && j_q != '0) ? j_q - TAP_W'(1) : TAP_W'(K - 1);
    assign w_sel = w_q[tap];
    assign prod  = (2*DATA_W)'($signed(ram_data_out)) * (2*DATA_W)'(w_sel);
    assign w_wr  = (state_q == ST_IDLE) && w_we && (32'(w_addr) < K);

    shift_sat u_shift_sat (
        .acc_i (acc_d),
        .sat_o (sat_res)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                end
            end
            ST_FETCH: begin
                if (j_q != '0) begin
                    acc_d = acc_q + ACC_W'(prod);
                end
                if (j_q == TAP_W'(K - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    j_d = j_q + TAP_W'(1);
                end
            end
            ST_DRAIN: begin
                acc_d   = acc_q + ACC_W'(prod);
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (i_q == ADDR_W'(N_OUT - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                        i_d     = i_q + ADDR_W'(1);
                        j_d     = '0;
                        acc_d   = '0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered copies of what the next state presents.
        rd_en_d = (state_d == ST_FETCH);
        addr_d  = rd_en_d ? i_d + ADDR_W'(j_d) : addr_q;
        valid_d = (state_d == ST_EMIT);
        data_d  = (state_q == ST_DRAIN) ? sat_res : data_q;
        index_d = (state_q == ST_DRAIN) ? i_q : index_q;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned k = 0; k < K; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            index_q <= index_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (w_wr) begin
                w_q[w_addr] <= w_data;
            end
        end
    end

    assign ram_addr_read   = addr_q;
    assign ram_read_enable = rd_en_q;
    assign out_valid       = valid_q;
    assign out_data        = data_q;
    assign out_index       = index_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
